timer: RTL and testbench
========================

// Module: timer
// PURPOSE
// - Programmable elapsed-time timer for the washing-machine controller.
// - Counts timer_period "seconds".
// - One second equals clk_freq clock cycles.
// - Raises done when the programmed interval has elapsed.
// - One instance is re-armed by the controller FSM for each wash phase:
//   enable low then high restarts the interval.
// PARAMETERS
// - CNT_W  16  width of clk_freq, timer_period and both internal counters
// PORTS
// - clk           in   1      rising-edge clock
// - reset         in   1      async active-low reset
// - enable        in   1      1 = run/hold the interval; 0 = clear and disarm
// - clk_freq      in   CNT_W  clock cycles per second (ticks/sec)
// - timer_period  in   CNT_W  interval length in seconds
// - done          out  1      interval elapsed (registered level)
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low.
// - reset=0: prescale counter, seconds counter and done all clear to 0
//   immediately; they stay 0 while reset is held.
// - enable=0 (reset=1): on each edge, prescale <= 0, seconds <= 0, done <= 0.
// - enable=1, done=0: each edge increments prescale.
//   - When prescale == eff_freq-1: prescale <= 0, seconds <= seconds+1
//     (second tick).
//   - eff_freq = (clk_freq==0) ? 1 : clk_freq.
// - done is registered.
//   - done <= 1 on the edge where the updated seconds value >= timer_period.
//   - Result: done rises on exactly the (eff_freq*timer_period)-th enabled
//     rising edge after enable/reset release.
// - Once done=1 with enable=1:
//   - counters freeze and done holds 1 (sticky);
//   - only enable=0 or reset clears it.
// - timer_period==0: done rises on the first enabled edge (latency 1 cycle).
// - Inputs are not latched; they are compared live every cycle.
//   - timer_period lowered mid-count to <= seconds: done on the next edge.
//   - timer_period raised mid-count: counting continues to the new value.
//   - clk_freq lowered below prescale+1 mid-count: the prescaler compares
//     with >=, so it wraps on the next edge (no 2^CNT_W overflow).
// - Seconds counter saturates at all-ones; it never wraps.
// - enable falling in the same cycle done would rise: enable wins,
//   done stays 0.
// - reset asserted mid-interval: immediate clear; the interval restarts from
//   0 after release if enable=1.
// - No combinational path from any input to done.
// TESTING
// - reset=0 held, enable=1, clk_freq=1, timer_period=3 -> done stays 0 for
//   the whole run.
// - reset released, enable=1, clk_freq=1, timer_period=3 -> done=0 after
//   edges 1-2; done=1 after edge 3; stays 1 for 20 further edges.
// - clk_freq=4, timer_period=2 -> done rises on edge 8, not on edge 7.
// - done=1, then enable=0 for one cycle, then enable=1 (freq=1, period=3)
//   -> done=0 after the enable-low edge; done=1 again 3 edges after re-enable.
// - clk_freq=0, timer_period=2 -> treated as freq 1, done on edge 2;
//   timer_period=0 -> done on edge 1.
// - freq=1, period=10; at edge 4 change period to 2 -> done on edge 5;
//   reset pulse at edge 6 -> done=0 asynchronously; done again 10 edges after
//   release once period is restored to 10.

Source files
------------

// File: rtl/timer.sv
// timer: counts timer_period seconds of clk_freq cycles each and raises a sticky registered done
module timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] clk_freq,
  input  logic [CNT_W-1:0] timer_period,
  output logic             done
);
  logic [CNT_W-1:0] presc, sec, eff_freq, presc_nxt, sec_nxt;
  logic             wrap;
  // >= rather than == so a lowered clk_freq wraps at once instead of running to overflow
  always_comb begin
    eff_freq  = (clk_freq == '0) ? CNT_W'(1) : clk_freq;
    wrap      = presc >= eff_freq - CNT_W'(1);
    presc_nxt = wrap ? '0 : presc + CNT_W'(1);
    sec_nxt   = (wrap && sec != '1) ? sec + CNT_W'(1) : sec;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      presc <= '0;
      sec   <= '0;
      done  <= 1'b0;
    end else if (!enable) begin
      presc <= '0;
      sec   <= '0;
      done  <= 1'b0;
    end else if (!done) begin
      presc <= presc_nxt;
      sec   <= sec_nxt;
      done  <= sec_nxt >= timer_period;
    end
endmodule

// File: tb/tb_timer.sv
// tb_timer: directed stimulus, integer reference model checked every cycle plus literal edge checks
module tb_timer;
  logic        clk = 0, reset = 0, enable = 1, done;
  logic [15:0] clk_freq = 1, timer_period = 3;
  int vec = 0, miss = 0;
  int m_ticks = 0, m_secs = 0;
  bit m_done = 0;

  timer #(.CNT_W(16)) dut (.clk(clk), .reset(reset), .enable(enable), .clk_freq(clk_freq),
    .timer_period(timer_period), .done(done));

  always #5 clk = ~clk;

  // model counts elapsed cycles inside the current second and whole seconds as plain integers
  always @(posedge clk or negedge reset) begin
    if (!reset || !enable) begin
      m_ticks = 0;
      m_secs  = 0;
      m_done  = 0;
    end else if (!m_done) begin
      m_ticks++;
      if (m_ticks >= ((clk_freq == 0) ? 1 : int'(clk_freq))) begin
        m_ticks = 0;
        if (m_secs < 65535) m_secs++;
      end
      m_done = m_secs >= int'(timer_period);
    end
  end

  always @(negedge clk) begin
    vec++;
    if (done !== m_done) begin
      miss++;
      $display("FAIL model t=%0t done=%b expected=%b", $time, done, m_done);
    end
  end

  task automatic chk(input string name, input bit exp);
    vec++;
    if (done !== exp) begin
      miss++;
      $display("FAIL %s t=%0t done=%b expected=%b", name, $time, done, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    for (int i = 0; i < 5; i++) begin edges(1); chk("reset_held", 0); end
    reset = 1;
    for (int i = 1; i <= 3; i++) begin edges(1); chk("f1p3", i == 3); end
    for (int i = 0; i < 20; i++) begin edges(1); chk("sticky", 1); end
    enable = 0; edges(1); chk("disarm", 0);
    enable = 1; clk_freq = 4; timer_period = 2;
    for (int i = 1; i <= 8; i++) begin edges(1); chk("f4p2", i == 8); end
    clk_freq = 1; timer_period = 3;
    enable = 0; edges(1); chk("rearm_low", 0);
    enable = 1;
    for (int i = 1; i <= 3; i++) begin edges(1); chk("rearm", i == 3); end
    enable = 0; edges(1);
    enable = 1; clk_freq = 0; timer_period = 2;
    for (int i = 1; i <= 2; i++) begin edges(1); chk("f0p2", i == 2); end
    enable = 0; edges(1);
    enable = 1; timer_period = 0; edges(1); chk("p0", 1);
    enable = 0; edges(1);
    enable = 1; clk_freq = 1; timer_period = 2; edges(1); chk("en_race1", 0);
    enable = 0; edges(1); chk("en_race2", 0);
    enable = 1; clk_freq = 10; timer_period = 1;
    for (int i = 1; i <= 5; i++) begin edges(1); chk("fdrop_pre", 0); end
    clk_freq = 3; edges(1); chk("fdrop", 1);
    enable = 0; edges(1);
    enable = 1; clk_freq = 1; timer_period = 10;
    for (int i = 1; i <= 4; i++) begin edges(1); chk("pchg_pre", 0); end
    timer_period = 2; edges(1); chk("pchg", 1);
    edges(1); chk("pre_reset", 1);
    #2 reset = 0; #1 chk("async_reset", 0);
    timer_period = 10; edges(1); chk("reset_hold", 0);
    reset = 1;
    for (int i = 1; i <= 10; i++) begin edges(1); chk("restart", i == 10); end
    edges(2);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
